data_mem_responder: RTL and testbench

//   Main-memory responder for the data cache: services writeback (evicted dirty word) and refill
//   (miss fill) requests with fixed, parameterised latency, removing the immediate-RAM-read

---
 rtl/data_mem_responder.sv | 145 ++++++++++++++
 tb/tb_data_mem_responder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-cache main-memory responder: writeback then refill against a word-organised store.
// Latency: WRITE_LAT cycles for the writeback phase, READ_LAT for the refill, plus one DONE cycle.
// Backpressure: req_ready only in IDLE; requests are held by the cache until accepted.
module data_mem_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 32,
  parameter int MEM_ADDR_BITS  = 17,
  parameter int READ_LAT       = 4,
  parameter int WRITE_LAT      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic                      req_re,
  input  logic [RAM_ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  input  logic [RAM_ADDR_WIDTH-1:0] fill_addr,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      busy
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam int DEPTH   = 2 ** MEM_ADDR_BITS;

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WB_LOAD = CNT_W'(WRITE_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_RD,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     re_q, re_d;
  logic [MEM_ADDR_BITS-1:0] wb_idx_q, wb_idx_d;
  logic [MEM_ADDR_BITS-1:0] fill_idx_q, fill_idx_d;
  logic [DATA_WIDTH-1:0]    wb_data_q, wb_data_d;
  logic [DATA_WIDTH-1:0]    resp_rdata_q, resp_rdata_d;
  logic                     mem_we;

  // Backing store: not reset, contents survive rst.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-offset and upper (aliased) address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wb_addr, fill_addr};

  // Next-state, counter and capture logic; one phase at a time, writeback always before refill.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    re_d         = re_q;
    wb_idx_d     = wb_idx_q;
    fill_idx_d   = fill_idx_q;
    wb_data_d    = wb_data_q;
    resp_rdata_d = resp_rdata_q;
    mem_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && (req_we || req_re)) begin
          re_d       = req_re;
          wb_idx_d   = wb_addr[MEM_ADDR_BITS+1:2];
          fill_idx_d = fill_addr[MEM_ADDR_BITS+1:2];
          wb_data_d  = wb_data;
          if (req_we) begin
            state_d = S_WB;
            cnt_d   = WB_LOAD;
          end else begin
            state_d = S_RD;
            cnt_d   = RD_LOAD;
          end
        end
      end
      S_WB: begin
        if (cnt_q == '0) begin
          mem_we = 1'b1;
          if (re_q) begin
            state_d = S_RD;
            cnt_d   = RD_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RD: begin
        if (cnt_q == '0) begin
          // The writeback (if any) committed in an earlier cycle, so same-word refills see new data.
          resp_rdata_d = mem[fill_idx_q];
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and captured-request registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      re_q         <= 1'b0;
      wb_idx_q     <= '0;
      fill_idx_q   <= '0;
      wb_data_q    <= '0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      re_q         <= re_d;
      wb_idx_q     <= wb_idx_d;
      fill_idx_q   <= fill_idx_d;
      wb_data_q    <= wb_data_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Store write port, committed on the last writeback cycle.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wb_idx_q] <= wb_data_q;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a response scoreboard.
// Driver pushes expected completion cycle/data on accept; monitor pops on resp_valid.
// Inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_re;
  logic [31:0] wb_addr;
  logic [31:0] wb_data;
  logic [31:0] fill_addr;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  data_mem_responder #(
    .DATA_WIDTH(32), .RAM_ADDR_WIDTH(32), .MEM_ADDR_BITS(17), .READ_LAT(4), .WRITE_LAT(4)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_re(req_re), .wb_addr(wb_addr), .wb_data(wb_data),
    .fill_addr(fill_addr), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every resp_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_cycle", cyc, e.cyc);
        if (e.chk_data) check("resp_rdata", resp_rdata, e.data);
      end
    end
  end

  // Present a request and wait for acceptance; t is the accept cycle.
  task automatic issue(input bit we, input bit re, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [31:0] fa, input int lat, input bit push, input bit chk,
                       input logic [31:0] ed, input bit hold, output int t);
    bit ok;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_re = re;
    wb_addr = wa; wb_data = wd; fill_addr = fa;
    ok = 1'b0;
    t  = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      t = cyc;
      if (push) exp_q.push_back('{cyc: t + lat + 1, chk_data: chk, data: ed});
    end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t, ta, tb;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_re = 1'b0;
    wb_addr = '0; wb_data = '0; fill_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", req_ready, 32'd1);
    check("reset_busy", busy, 32'd0);
    check("reset_resp_valid", resp_valid, 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);

    // 1: reset in the middle of a refill drops it
    issue(1'b0, 1'b1, 32'h0, 32'h0, 32'h40, 4, 1'b0, 1'b0, 32'h0, 1'b0, t);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("midrd_rst_ready", req_ready, 32'd1);
    check("midrd_rst_busy", busy, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrd_no_resp_pending", exp_q.size(), 32'd0);

    // Preload store word 0x10 through a writeback; rdata must stay at reset value
    issue(1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 32'h0, 4, 1'b1, 1'b1, 32'h0, 1'b0, t);
    drain();

    // 2: refill of 0x40 with busy window T+1..T+5
    issue(1'b0, 1'b1, 32'h0, 32'h0, 32'h40, 4, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, t);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("busy_T+%0d", k), busy, (k <= 5) ? 32'd1 : 32'd0);
    end
    drain();

    // 3: writeback only leaves rdata untouched, later refill sees it
    issue(1'b1, 1'b0, 32'h80, 32'h12345678, 32'h40, 4, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, t);
    drain();
    issue(1'b0, 1'b1, 32'h0, 32'h0, 32'h80, 4, 1'b1, 1'b1, 32'h12345678, 1'b0, t);
    drain();

    // 4: writeback and refill of the same word
    issue(1'b1, 1'b1, 32'h100, 32'hCAFEF00D, 32'h100, 8, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0, t);
    drain();

    // 5: back-to-back with valid held and inputs scrambled while busy
    issue(1'b0, 1'b1, 32'h0, 32'h0, 32'h80, 4, 1'b1, 1'b1, 32'h12345678, 1'b1, ta);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      req_valid = k[0]; req_we = 1'b1; req_re = 1'b1;
      wb_addr = 32'h80; wb_data = 32'hBAD0BAD0 + k; fill_addr = 32'h40 + 32'(k);
    end
    issue(1'b0, 1'b1, 32'h0, 32'h0, 32'h100, 4, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0, tb);
    check("b2b_accept_cycle", tb, ta + 6);
    drain();
    issue(1'b0, 1'b1, 32'h0, 32'h0, 32'h80, 4, 1'b1, 1'b1, 32'h12345678, 1'b0, t);
    drain();

    // 6: request with neither we nor re is never accepted
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_re = 1'b0; wb_addr = 32'h80; fill_addr = 32'h80;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("noop_busy", busy, 32'd0);
    end
    @(posedge clk); #1 req_valid = 1'b0;

    // Aliasing: bit 19 of the byte address is above the 17-bit word index
    issue(1'b1, 1'b0, 32'h0, 32'hA5A55A5A, 32'h0, 4, 1'b1, 1'b0, 32'h0, 1'b0, t);
    drain();
    issue(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 4, 1'b1, 1'b1, 32'hA5A55A5A, 1'b0, t);
    drain();
    issue(1'b0, 1'b1, 32'h0, 32'h0, 32'h0008_0000, 4, 1'b1, 1'b1, 32'hA5A55A5A, 1'b0, t);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
